// File: rtl/data_mem_lsu_if.sv
// Load/store request and response bundle between the CPU data side and data_mem_lsu.
interface data_mem_lsu_if;
    logic        rd_req_i;
    logic [1:0]  acc_r_i;
    logic        sext_i;
    logic [31:0] addr_r_i;
    logic [31:0] data_r_o;
    logic        rd_valid_o;
    logic        wr_en_i;
    logic [1:0]  acc_w_i;
    logic [31:0] addr_w_i;
    logic [31:0] data_w_i;
    logic        wr_ready_o;
    logic        busy_o;
    logic        err_o;
    logic [31:0] err_addr_o;

    // Core side: issues requests, consumes responses.
    modport master (
        output rd_req_i, acc_r_i, sext_i, addr_r_i,
        output wr_en_i, acc_w_i, addr_w_i, data_w_i,
        input  data_r_o, rd_valid_o, wr_ready_o, busy_o, err_o, err_addr_o
    );

    // Memory side: serves requests, produces responses.
    modport slave (
        input  rd_req_i, acc_r_i, sext_i, addr_r_i,
        input  wr_en_i, acc_w_i, addr_w_i, data_w_i,
        output data_r_o, rd_valid_o, wr_ready_o, busy_o, err_o, err_addr_o
    );
endinterface

// File: rtl/data_mem_lsu.sv
// Load/store unit with on-chip data RAM: byte/half/word loads with extension,
// single-cycle word stores, read-modify-write sub-word stores, fault flagging.
module data_mem_lsu #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] ADDR_BASE   = 32'h0001_0000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    data_mem_lsu_if.slave  bus
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

    typedef enum logic {IDLE, MERGE} state_t;

    // ---------------- request decode ----------------
    logic [31:0]   rd_off, wr_off;
    logic [AW-1:0] rd_idx, wr_idx;
    logic          wr_req, rd_req;
    logic          rd_fault, wr_fault;

    assign rd_off = bus.addr_r_i - ADDR_BASE;   // underflow lands far above SPAN
    assign wr_off = bus.addr_w_i - ADDR_BASE;
    assign rd_idx = rd_off[AW+1:2];
    assign wr_idx = wr_off[AW+1:2];

    // Classify incoming requests; a store shadows a same-cycle load.
    always_comb begin
        wr_req   = bus.wr_en_i && (bus.acc_w_i != 2'b11);
        rd_req   = bus.rd_req_i && (bus.acc_r_i != 2'b11) && !wr_req;
        rd_fault = (rd_off >= SPAN)
                 || ((bus.acc_r_i == 2'b01) && bus.addr_r_i[0])
                 || ((bus.acc_r_i == 2'b10) && (bus.addr_r_i[1:0] != 2'b00));
        wr_fault = (wr_off >= SPAN)
                 || ((bus.acc_w_i == 2'b01) && bus.addr_w_i[0])
                 || ((bus.acc_w_i == 2'b10) && (bus.addr_w_i[1:0] != 2'b00));
    end

    // ---------------- state ----------------
    state_t        state_q, state_d;
    logic          rd_valid_q, rd_valid_d;
    logic          wr_ready_q, wr_ready_d;
    logic          err_q, err_d;
    logic [31:0]   err_addr_q, err_addr_d;
    logic          ld_ok_q, ld_ok_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic          ld_sext_q, ld_sext_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic [AW-1:0] st_idx_q, st_idx_d;
    logic [3:0]    st_be_q, st_be_d;
    logic [31:0]   st_data_q, st_data_d;
    logic [31:0]   data_hold_q, data_hold_d;

    // ---------------- RAM ----------------
    logic [31:0]   mem [0:DEPTH_WORDS-1];
    logic [31:0]   ram_rdata_q;
    logic          ram_re, ram_we;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [31:0]   ram_wdata;
    logic [31:0]   merged;
    logic          idle_go, st_word_go, st_sub_go, ld_go;

    // Accepted, non-faulting operations that touch the RAM this cycle.
    always_comb begin
        idle_go    = (state_q == IDLE) && !rst_i;
        st_word_go = idle_go && wr_req && !wr_fault && (bus.acc_w_i == 2'b10);
        st_sub_go  = idle_go && wr_req && !wr_fault && (bus.acc_w_i != 2'b10);
        ld_go      = idle_go && rd_req && !rd_fault;
        ram_re     = ld_go || st_sub_go;
        ram_raddr  = st_sub_go ? wr_idx : rd_idx;
        ram_we     = st_word_go || ((state_q == MERGE) && !rst_i);
        ram_waddr  = (state_q == MERGE) ? st_idx_q : wr_idx;
        ram_wdata  = (state_q == MERGE) ? merged : bus.data_w_i;
    end

    // Byte-lane merge of latched store data into the word just read back.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[8*gi +: 8] = st_be_q[gi] ? st_data_q[8*gi +: 8]
                                                   : ram_rdata_q[8*gi +: 8];
        end
    endgenerate

    // Single-port-style RAM: synchronous write, registered read, never cleared.
    always_ff @(posedge clk_i) begin
        if (ram_we) mem[ram_waddr] <= ram_wdata;
        if (ram_re) ram_rdata_q <= mem[ram_raddr];
    end

    // ---------------- load result formatting ----------------
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;
    logic [31:0] load_result;

    // Right-align the addressed lane and extend it; hold the last result otherwise.
    always_comb begin
        ld_shift = ram_rdata_q >> {ld_off_q, 3'b000};
        case (ld_size_q)
            2'b00:   ld_ext = {{24{ld_sext_q & ld_shift[7]}},  ld_shift[7:0]};
            2'b01:   ld_ext = {{16{ld_sext_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ram_rdata_q;
        endcase
        load_result = ld_ok_q ? ld_ext : data_hold_q;
    end

    // Next-state and registered-response computation.
    always_comb begin
        state_d     = state_q;
        rd_valid_d  = 1'b0;
        wr_ready_d  = 1'b0;
        err_d       = 1'b0;
        err_addr_d  = err_addr_q;
        ld_ok_d     = 1'b0;
        ld_size_d   = ld_size_q;
        ld_sext_d   = ld_sext_q;
        ld_off_d    = ld_off_q;
        st_idx_d    = st_idx_q;
        st_be_d     = st_be_q;
        st_data_d   = st_data_q;
        data_hold_d = load_result;

        if (rst_i) begin
            state_d     = IDLE;
            err_addr_d  = 32'h0;
            data_hold_d = 32'h0;
        end else if (state_q == MERGE) begin
            // Merged word is written at this edge; the store completes next cycle.
            state_d    = IDLE;
            wr_ready_d = 1'b1;
        end else if (wr_req) begin
            if (wr_fault) begin
                err_d      = 1'b1;
                err_addr_d = bus.addr_w_i;
                wr_ready_d = 1'b1;
            end else if (bus.acc_w_i == 2'b10) begin
                wr_ready_d = 1'b1;
            end else begin
                state_d   = MERGE;
                st_idx_d  = wr_idx;
                st_be_d   = (bus.acc_w_i == 2'b00) ? (4'b0001 << wr_off[1:0])
                                                   : (wr_off[1] ? 4'b1100 : 4'b0011);
                st_data_d = (bus.acc_w_i == 2'b00) ? {4{bus.data_w_i[7:0]}}
                                                   : {2{bus.data_w_i[15:0]}};
            end
        end else if (rd_req) begin
            rd_valid_d = 1'b1;
            if (rd_fault) begin
                err_d       = 1'b1;
                err_addr_d  = bus.addr_r_i;
                data_hold_d = 32'h0;
            end else begin
                ld_ok_d   = 1'b1;
                ld_size_d = bus.acc_r_i;
                ld_sext_d = bus.sext_i;
                ld_off_d  = rd_off[1:0];
            end
        end
    end

    // FSM and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            rd_valid_q  <= 1'b0;
            wr_ready_q  <= 1'b0;
            err_q       <= 1'b0;
            err_addr_q  <= 32'h0;
            ld_ok_q     <= 1'b0;
            ld_size_q   <= 2'b10;
            ld_sext_q   <= 1'b0;
            ld_off_q    <= 2'b00;
            st_idx_q    <= '0;
            st_be_q     <= 4'b0000;
            st_data_q   <= 32'h0;
            data_hold_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            rd_valid_q  <= rd_valid_d;
            wr_ready_q  <= wr_ready_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            ld_ok_q     <= ld_ok_d;
            ld_size_q   <= ld_size_d;
            ld_sext_q   <= ld_sext_d;
            ld_off_q    <= ld_off_d;
            st_idx_q    <= st_idx_d;
            st_be_q     <= st_be_d;
            st_data_q   <= st_data_d;
            data_hold_q <= data_hold_d;
        end
    end

    assign bus.data_r_o   = load_result;
    assign bus.rd_valid_o = rd_valid_q;
    assign bus.wr_ready_o = wr_ready_q;
    assign bus.busy_o     = (state_q == MERGE);
    assign bus.err_o      = err_q;
    assign bus.err_addr_o = err_addr_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: stores, loads, faults, priority, busy drop, reset in MERGE.
module tb_data_mem_lsu;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   errors = 0;
    int   checks = 0;

    data_mem_lsu_if bus ();

    data_mem_lsu #(
        .DEPTH_WORDS(1024),
        .ADDR_BASE  (32'h0001_0000)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_req();
        bus.rd_req_i = 1'b0;
        bus.wr_en_i  = 1'b0;
        bus.acc_r_i  = 2'b11;
        bus.acc_w_i  = 2'b11;
        bus.sext_i   = 1'b0;
        bus.addr_r_i = 32'h0;
        bus.addr_w_i = 32'h0;
        bus.data_w_i = 32'h0;
    endtask

    // One load transaction; checks the response one cycle later.
    task automatic load_chk(input string tag, input logic [1:0] size, input logic sext,
                            input logic [31:0] addr, input logic [31:0] exp_data,
                            input logic exp_err);
        bus.rd_req_i = 1'b1;
        bus.acc_r_i  = size;
        bus.sext_i   = sext;
        bus.addr_r_i = addr;
        tick();
        clear_req();
        $display("load  %-12s size=%0d sext=%0d addr=%h data=%h err=%0d",
                 tag, size, sext, addr, bus.data_r_o, bus.err_o);
        check({tag, ".rd_valid"}, 32'(bus.rd_valid_o), 32'h1);
        check({tag, ".data"}, bus.data_r_o, exp_data);
        check({tag, ".err"}, 32'(bus.err_o), 32'(exp_err));
    endtask

    // One store transaction; sub-word stores expect busy then a late ready.
    task automatic store_chk(input string tag, input logic [1:0] size,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic exp_err);
        bus.wr_en_i  = 1'b1;
        bus.acc_w_i  = size;
        bus.addr_w_i = addr;
        bus.data_w_i = data;
        tick();
        clear_req();
        if (size != 2'b10 && !exp_err) begin
            check({tag, ".busy"}, 32'(bus.busy_o), 32'h1);
            check({tag, ".early_ready"}, 32'(bus.wr_ready_o), 32'h0);
            tick();
        end
        $display("store %-12s size=%0d addr=%h data=%h err=%0d",
                 tag, size, addr, data, bus.err_o);
        check({tag, ".wr_ready"}, 32'(bus.wr_ready_o), 32'h1);
        check({tag, ".busy_end"}, 32'(bus.busy_o), 32'h0);
        check({tag, ".err"}, 32'(bus.err_o), 32'(exp_err));
    endtask

    initial begin
        clear_req();
        rst_i = 1'b1;
        tick();
        tick();
        check("rst.data_r",   bus.data_r_o, 32'h0);
        check("rst.rd_valid", 32'(bus.rd_valid_o), 32'h0);
        check("rst.wr_ready", 32'(bus.wr_ready_o), 32'h0);
        check("rst.busy",     32'(bus.busy_o), 32'h0);
        check("rst.err",      32'(bus.err_o), 32'h0);
        check("rst.err_addr", bus.err_addr_o, 32'h0);
        rst_i = 1'b0;
        tick();

        // Word store and readback, then result holds after the pulse.
        store_chk("sw_4", 2'b10, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0);
        load_chk("lw_4", 2'b10, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("hold.rd_valid", 32'(bus.rd_valid_o), 32'h0);
        check("hold.data", bus.data_r_o, 32'hDEAD_BEEF);

        // Byte store via read-modify-write.
        store_chk("sb_5", 2'b00, 32'h0001_0005, 32'h0000_0080, 1'b0);
        load_chk("lw_after_sb", 2'b10, 1'b0, 32'h0001_0004, 32'hDEAD_80EF, 1'b0);
        load_chk("lb_sext", 2'b00, 1'b1, 32'h0001_0005, 32'hFFFF_FF80, 1'b0);
        load_chk("lb_zext", 2'b00, 1'b0, 32'h0001_0005, 32'h0000_0080, 1'b0);

        // Half store via read-modify-write.
        store_chk("sh_6", 2'b01, 32'h0001_0006, 32'h0000_1234, 1'b0);
        load_chk("lw_after_sh", 2'b10, 1'b0, 32'h0001_0004, 32'h1234_80EF, 1'b0);
        load_chk("lh_6_sext", 2'b01, 1'b1, 32'h0001_0006, 32'h0000_1234, 1'b0);
        load_chk("lh_4_sext", 2'b01, 1'b1, 32'h0001_0004, 32'hFFFF_80EF, 1'b0);

        // Faults.
        load_chk("lw_misal", 2'b10, 1'b0, 32'h0001_0002, 32'h0, 1'b1);
        check("lw_misal.err_addr", bus.err_addr_o, 32'h0001_0002);
        store_chk("sw_0", 2'b10, 32'h0001_0000, 32'h1122_3344, 1'b0);
        store_chk("sh_misal", 2'b01, 32'h0001_0001, 32'h0000_FFFF, 1'b1);
        check("sh_misal.err_addr", bus.err_addr_o, 32'h0001_0001);
        load_chk("lw_0_unchg", 2'b10, 1'b0, 32'h0001_0000, 32'h1122_3344, 1'b0);
        store_chk("sw_oor", 2'b10, 32'h0001_1000, 32'h0BAD_0BAD, 1'b1);
        check("sw_oor.err_addr", bus.err_addr_o, 32'h0001_1000);
        store_chk("sw_last", 2'b10, 32'h0001_0FFC, 32'hCAFE_F00D, 1'b0);
        load_chk("lw_last", 2'b10, 1'b0, 32'h0001_0FFC, 32'hCAFE_F00D, 1'b0);
        load_chk("lw_under", 2'b10, 1'b0, 32'h0000_FFFC, 32'h0, 1'b1);
        check("lw_under.err_addr", bus.err_addr_o, 32'h0000_FFFC);

        // Simultaneous store and load: only the store runs.
        bus.wr_en_i  = 1'b1;
        bus.acc_w_i  = 2'b10;
        bus.addr_w_i = 32'h0001_0008;
        bus.data_w_i = 32'h5566_7788;
        bus.rd_req_i = 1'b1;
        bus.acc_r_i  = 2'b10;
        bus.addr_r_i = 32'h0001_0004;
        tick();
        clear_req();
        $display("both  store addr=00010008 data=55667788 with load addr=00010004");
        check("both.wr_ready", 32'(bus.wr_ready_o), 32'h1);
        check("both.rd_valid", 32'(bus.rd_valid_o), 32'h0);
        load_chk("lw_8", 2'b10, 1'b0, 32'h0001_0008, 32'h5566_7788, 1'b0);

        // Load issued during MERGE is dropped.
        bus.wr_en_i  = 1'b1;
        bus.acc_w_i  = 2'b00;
        bus.addr_w_i = 32'h0001_0008;
        bus.data_w_i = 32'h0000_0011;
        tick();
        clear_req();
        check("drop.busy", 32'(bus.busy_o), 32'h1);
        bus.rd_req_i = 1'b1;
        bus.acc_r_i  = 2'b10;
        bus.addr_r_i = 32'h0001_0004;
        tick();
        clear_req();
        $display("drop  load addr=00010004 issued while busy");
        check("drop.wr_ready", 32'(bus.wr_ready_o), 32'h1);
        check("drop.rd_valid0", 32'(bus.rd_valid_o), 32'h0);
        tick();
        check("drop.rd_valid1", 32'(bus.rd_valid_o), 32'h0);
        load_chk("lw_8_sb", 2'b10, 1'b0, 32'h0001_0008, 32'h5566_7711, 1'b0);
        load_chk("lw_4_reiss", 2'b10, 1'b0, 32'h0001_0004, 32'h1234_80EF, 1'b0);

        // Reset during MERGE suppresses the write and the ready pulse.
        bus.wr_en_i  = 1'b1;
        bus.acc_w_i  = 2'b00;
        bus.addr_w_i = 32'h0001_0004;
        bus.data_w_i = 32'h0000_00AA;
        tick();
        clear_req();
        check("rstm.busy", 32'(bus.busy_o), 32'h1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        $display("reset asserted during MERGE of byte store addr=00010004");
        check("rstm.busy_after", 32'(bus.busy_o), 32'h0);
        check("rstm.wr_ready",   32'(bus.wr_ready_o), 32'h0);
        check("rstm.rd_valid",   32'(bus.rd_valid_o), 32'h0);
        check("rstm.err",        32'(bus.err_o), 32'h0);
        check("rstm.err_addr",   bus.err_addr_o, 32'h0);
        check("rstm.data_r",     bus.data_r_o, 32'h0);
        tick();
        check("rstm.no_late_ready", 32'(bus.wr_ready_o), 32'h0);
        load_chk("lw_4_unchg", 2'b10, 1'b0, 32'h0001_0004, 32'h1234_80EF, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
